msx_spi_frame_rx: RTL and testbench
===================================

// Module: msx_spi_frame_rx
// PURPOSE
//  SPI-slave front end for the MSX bus bridge, sitting upstream of the Z80 bus-cycle engine.
//  Oversamples the host SPI link (mode 0, MSB first) in the clk domain and decodes 4-byte frames
//  {cmd, addr_lo, addr_hi, wdata}. Each valid frame becomes one bus request on a valid/ready handshake.
//  Returns status and the last read byte to the host on MISO during the following frame.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth on spi_cs/spi_clk/spi_mosi (>=2)
//  CMD_MAX      4  highest legal command code (1=MRD 2=MWR 3=IORD 4=IOWR; 0=NOP/status poll)
// PORTS
//  clk        in   1   system clock; spi_clk high and low phases must each last >=SYNC_STAGES+2 clk
//  z80_reset  in   1   asynchronous, active-low reset
//  spi_cs     in   1   chip select, active-low, asynchronous to clk
//  spi_clk    in   1   SPI clock, mode 0, asynchronous to clk
//  spi_mosi   in   1   SPI data in
//  spi_miso   out  1   SPI data out
//  req_valid  out  1   bus request pending to engine
//  req_ready  in   1   engine accepts request (handshake completes when valid&ready at posedge clk)
//  req_cmd    out  8   command byte (1..CMD_MAX)
//  req_addr   out  16  {addr_hi, addr_lo}
//  req_wdata  out  8   write data (don't-care for reads)
//  rsp_valid  in   1   1-clk pulse from engine when an accepted request finishes (every cmd)
//  rsp_rdata  in   8   read data, valid with rsp_valid
//  frame_err  out  1   1-clk pulse: bad cmd, dropped frame (overrun) or partial frame at CS rise
// BEHAVIOUR
//  Reset: all outputs 0; counters, flags, rd_hold (8'h00), in_flight cleared; abandons any frame/request.
//  Sync: SYNC_STAGES FFs per SPI input; edges are detected on the synced spi_clk.
//   Rise: shift in MOSI. Fall: advance MISO.
//  Framing: bit_cnt 0..7 and byte_cnt 0..3 run while synced spi_cs=0; both clear while spi_cs=1.
//   byte_cnt wraps 3->0, so back-to-back frames under one CS assertion are legal.
//  CS rise with byte_cnt!=0 or bit_cnt!=0: partial frame discarded, frame_err pulses once.
//  Byte 3 completes (8th rise), clk cycle after the edge detect:
//   cmd==0: no request (status poll).
//   cmd>CMD_MAX: frame_err pulse; cmd_err flag set.
//   cmd legal and free: latch req_cmd/req_addr/req_wdata; req_valid=1 next clk. free = !req_valid && (!in_flight || rsp_valid).
//   cmd legal and not free: frame dropped; frame_err pulse; overrun flag set.
//  Handshake: req_valid holds, with stable req_* fields, until req_valid&req_ready.
//   req_valid drops the next clk; in_flight=1 from that handshake until rsp_valid.
//  rsp_valid: rd_hold<=rsp_rdata, done<=1, in_flight<=0.
//   rsp_valid with no in_flight is ignored.
//   rsp_valid and a completing frame in the same clk: both take effect; the new request is accepted.
//  MISO: tx_shift loads at each byte start (CS fall, or the fall after bit 7); spi_miso=tx_shift[7].
//   Byte 0 = status {busy=req_valid|in_flight, done, overrun, cmd_err, 4'b0000}.
//   Byte 1 = rd_hold; bytes 2 and 3 = 8'h00.
//   Bit 7 is valid on MISO before the first rise after CS fall; shift left on each fall.
//   spi_miso=0 while CS is high.
//  Flag clears: overrun and cmd_err clear when byte 0 completes; done clears when byte 1 completes.
//   A same-clk set wins over a clear.
// TESTING
//  1 Reset idle; frame 02 34 12 A5 (MWR) -> req_valid=1, cmd=02, addr=1234, wdata=A5.
//    Hold req_ready=0 for 5 clk -> fields stable; assert ready -> req_valid=0 next clk.
//  2 MRD frame 01 00 40 00; engine rsp_valid rdata=5A -> next frame MISO byte0=0x40 (done), byte1=0x5A.
//    Third frame byte0=0x00.
//  3 Second legal frame while in_flight -> frame_err pulse, no new req.
//    Next status byte=0x A0 (busy|overrun) while in flight; overrun cleared after it.
//  4 Frame 07 00 00 00 -> frame_err, no req_valid, next status byte=0x10.
//    Frame 00 xx xx xx -> no req, no err.
//  5 CS rises after 2 bytes -> frame_err pulse, no req.
//    Next full frame 04 99 00 3C -> req cmd=04 addr=0099 wdata=3C.
//  6 Two frames back-to-back under one CS; z80_reset pulse mid-byte -> all outputs 0, counters cleared;
//    next CS frame decodes correctly.

Source files
------------

// File: rtl/msx_spi_frame_rx_if.sv
// Bus-request handshake between the SPI frame receiver
// and the Z80 bus-cycle engine.
interface msx_spi_frame_rx_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;

  modport master (
    output req_valid,
    input  req_ready,
    output req_cmd,
    output req_addr,
    output req_wdata,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_cmd,
    input  req_addr,
    input  req_wdata,
    output rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/msx_spi_frame_rx.sv
// SPI-slave (mode 0, MSB first) front end: oversamples the link,
// decodes 4-byte frames into bus requests, returns status/read data.
module msx_spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_MAX     = 4
) (
  input  logic clk,
  input  logic z80_reset,
  input  logic spi_cs,
  input  logic spi_clk,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic frame_err,
  msx_spi_frame_rx_if.master bus
);

  localparam logic [7:0] CMD_LIM = 8'(CMD_MAX);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic cs_s, sclk_s, mosi_s;
  logic cs_d, sclk_d;
  logic rise, fall, cs_fall, cs_rise;

  logic [2:0] bit_cnt;
  logic [1:0] byte_cnt;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] tx_sel;
  logic [7:0] byte_in;
  logic [7:0] b_cmd, b_lo, b_hi, b_wd;
  logic       frame_done;
  logic       load_pend;
  logic       bit_last;

  logic       in_flight;
  logic       done;
  logic       overrun;
  logic       cmd_err;
  logic [7:0] rd_hold;
  logic [7:0] status;

  logic cmd_zero, cmd_bad, free;
  logic accept, drop, hs, rsp_ok;
  logic byte0_done, byte1_done;
  logic partial;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign rise    = sclk_s & ~sclk_d & ~cs_s;
  assign fall    = ~sclk_s & sclk_d & ~cs_s;
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;

  assign bit_last = rise && (bit_cnt == 3'd7);
  assign byte_in  = {rx_shift[6:0], mosi_s};

  assign status = {bus.req_valid | in_flight, done,
                   overrun, cmd_err, 4'b0000};

  // Byte presented on MISO for the byte about to start.
  always_comb begin
    tx_sel = 8'h00;
    unique case (byte_cnt)
      2'd0:    tx_sel = status;
      2'd1:    tx_sel = rd_hold;
      default: tx_sel = 8'h00;
    endcase
  end

  assign cmd_zero = (b_cmd == 8'h00);
  assign cmd_bad  = (b_cmd > CMD_LIM);
  assign free     = !bus.req_valid &&
                    (!in_flight || bus.rsp_valid);
  assign accept   = frame_done && !cmd_zero && !cmd_bad && free;
  assign drop     = frame_done && !cmd_zero && !cmd_bad && !free;
  assign hs       = bus.req_valid && bus.req_ready;
  assign rsp_ok   = bus.rsp_valid && in_flight;

  assign byte0_done = bit_last && (byte_cnt == 2'd0);
  assign byte1_done = bit_last && (byte_cnt == 2'd1);
  assign partial    = cs_rise &&
                      ((byte_cnt != 2'd0) || (bit_cnt != 3'd0));

  assign spi_miso = ~cs_s & tx_shift[7];

  // Synchronise SPI pins and keep previous synced levels for edges.
  always_ff @(posedge clk or negedge z80_reset) begin
    if (!z80_reset) begin
      cs_sync   <= '1;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  // Bit/byte framing, receive shift and MISO shift register.
  always_ff @(posedge clk or negedge z80_reset) begin
    if (!z80_reset) begin
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      b_cmd      <= '0;
      b_lo       <= '0;
      b_hi       <= '0;
      b_wd       <= '0;
      frame_done <= 1'b0;
      load_pend  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_s) begin
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        load_pend <= 1'b0;
      end else begin
        if (rise) begin
          rx_shift <= byte_in;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_cnt  <= byte_cnt + 2'd1;
            load_pend <= 1'b1;
            unique case (byte_cnt)
              2'd0: b_cmd <= byte_in;
              2'd1: b_lo  <= byte_in;
              2'd2: b_hi  <= byte_in;
              2'd3: begin
                b_wd       <= byte_in;
                frame_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        if (fall) begin
          if (load_pend) begin
            tx_shift  <= tx_sel;
            load_pend <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        if (cs_fall)
          tx_shift <= tx_sel;
      end
    end
  end

  // Request issue, handshake and in-flight tracking.
  always_ff @(posedge clk or negedge z80_reset) begin
    if (!z80_reset) begin
      bus.req_valid <= 1'b0;
      bus.req_cmd   <= '0;
      bus.req_addr  <= '0;
      bus.req_wdata <= '0;
      in_flight     <= 1'b0;
      rd_hold       <= 8'h00;
    end else begin
      if (accept) begin
        bus.req_valid <= 1'b1;
        bus.req_cmd   <= b_cmd;
        bus.req_addr  <= {b_hi, b_lo};
        bus.req_wdata <= b_wd;
      end else if (hs) begin
        bus.req_valid <= 1'b0;
      end
      if (hs)
        in_flight <= 1'b1;
      else if (rsp_ok)
        in_flight <= 1'b0;
      if (rsp_ok)
        rd_hold <= bus.rsp_rdata;
    end
  end

  // Sticky status flags; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge z80_reset) begin
    if (!z80_reset) begin
      done    <= 1'b0;
      overrun <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      if (rsp_ok)
        done <= 1'b1;
      else if (byte1_done)
        done <= 1'b0;
      if (drop)
        overrun <= 1'b1;
      else if (byte0_done)
        overrun <= 1'b0;
      if (frame_done && cmd_bad)
        cmd_err <= 1'b1;
      else if (byte0_done)
        cmd_err <= 1'b0;
    end
  end

  // One-cycle error pulse for bad, dropped or partial frames.
  always_ff @(posedge clk or negedge z80_reset) begin
    if (!z80_reset)
      frame_err <= 1'b0;
    else
      frame_err <= partial || (frame_done && cmd_bad) || drop;
  end

endmodule

// File: tb/tb_msx_spi_frame_rx.sv
// Directed bench for msx_spi_frame_rx: frames, handshake,
// status bytes, error pulses and reset recovery.
module tb_msx_spi_frame_rx;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic z80_reset;
  logic cs, sclk, mosi;
  logic miso;
  logic frame_err;
  int   total = 0;
  int   bad = 0;
  int   ferr_n = 0;
  int   e0;
  logic [7:0] r0, r1, t;

  msx_spi_frame_rx_if bus ();

  msx_spi_frame_rx #(.SYNC_STAGES(2), .CMD_MAX(4)) dut (
    .clk       (clk),
    .z80_reset (z80_reset),
    .spi_cs    (cs),
    .spi_clk   (sclk),
    .spi_mosi  (mosi),
    .spi_miso  (miso),
    .frame_err (frame_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_err === 1'b1) ferr_n++;

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx,
                      output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      wclk(HALF);
      rx[i] = miso;
      sclk = 1'b1;
      wclk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic send4(input logic [7:0] a, b, c, d,
                       output logic [7:0] q0, q1);
    logic [7:0] dump;
    xfer(a, q0);
    xfer(b, q1);
    xfer(c, dump);
    xfer(d, dump);
  endtask

  task automatic frame(input logic [7:0] a, b, c, d,
                       output logic [7:0] q0, q1);
    cs = 1'b0;
    wclk(HALF);
    send4(a, b, c, d, q0, q1);
    wclk(HALF);
    cs = 1'b1;
    wclk(12);
  endtask

  task automatic handshake();
    bus.req_ready = 1'b1;
    wclk(1);
    bus.req_ready = 1'b0;
  endtask

  task automatic respond(input logic [7:0] d);
    bus.rsp_valid = 1'b1;
    bus.rsp_rdata = d;
    wclk(1);
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 8'h00;
    wclk(2);
  endtask

  initial begin
    z80_reset = 1'b0;
    cs = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 8'h00;
    wclk(3);
    chk("rst_valid", {31'd0, bus.req_valid}, 0);
    chk("rst_cmd", {24'd0, bus.req_cmd}, 0);
    chk("rst_addr", {16'd0, bus.req_addr}, 0);
    chk("rst_miso", {31'd0, miso}, 0);
    chk("rst_ferr", {31'd0, frame_err}, 0);
    z80_reset = 1'b1;
    wclk(4);

    // 1: MWR frame, ready held low then asserted
    frame(8'h02, 8'h34, 8'h12, 8'hA5, r0, r1);
    chk("t1_stat", {24'd0, r0}, 32'h00);
    chk("t1_valid", {31'd0, bus.req_valid}, 1);
    chk("t1_cmd", {24'd0, bus.req_cmd}, 32'h02);
    chk("t1_addr", {16'd0, bus.req_addr}, 32'h1234);
    chk("t1_wdata", {24'd0, bus.req_wdata}, 32'hA5);
    wclk(5);
    chk("t1_hold_v", {31'd0, bus.req_valid}, 1);
    chk("t1_hold_a", {16'd0, bus.req_addr}, 32'h1234);
    chk("t1_hold_w", {24'd0, bus.req_wdata}, 32'hA5);
    handshake();
    chk("t1_drop", {31'd0, bus.req_valid}, 0);
    respond(8'h00);

    // 2: MRD, read data returned in following frame
    frame(8'h01, 8'h00, 8'h40, 8'h00, r0, r1);
    chk("t2_stat0", {24'd0, r0}, 32'h40);
    chk("t2_valid", {31'd0, bus.req_valid}, 1);
    chk("t2_addr", {16'd0, bus.req_addr}, 32'h4000);
    handshake();
    respond(8'h5A);
    frame(8'h00, 8'h00, 8'h00, 8'h00, r0, r1);
    chk("t2_stat1", {24'd0, r0}, 32'h40);
    chk("t2_rd", {24'd0, r1}, 32'h5A);
    frame(8'h00, 8'h00, 8'h00, 8'h00, r0, r1);
    chk("t2_stat2", {24'd0, r0}, 32'h00);

    // 3: overrun while a request is in flight
    frame(8'h01, 8'h11, 8'h22, 8'h00, r0, r1);
    handshake();
    e0 = ferr_n;
    frame(8'h02, 8'h33, 8'h44, 8'h55, r0, r1);
    chk("t3_ferr", ferr_n - e0, 1);
    chk("t3_noreq", {31'd0, bus.req_valid}, 0);
    frame(8'h00, 8'h00, 8'h00, 8'h00, r0, r1);
    chk("t3_stat", {24'd0, r0}, 32'hA0);
    respond(8'h33);
    frame(8'h00, 8'h00, 8'h00, 8'h00, r0, r1);
    chk("t3_ovclr", {24'd0, r0}, 32'h40);

    // 4: illegal command, then status poll
    e0 = ferr_n;
    frame(8'h07, 8'h00, 8'h00, 8'h00, r0, r1);
    chk("t4_ferr", ferr_n - e0, 1);
    chk("t4_noreq", {31'd0, bus.req_valid}, 0);
    e0 = ferr_n;
    frame(8'h00, 8'hFF, 8'hFF, 8'hFF, r0, r1);
    chk("t4_stat", {24'd0, r0}, 32'h10);
    chk("t4_poll_e", ferr_n - e0, 0);
    chk("t4_poll_v", {31'd0, bus.req_valid}, 0);

    // 5: partial frame then full frame
    e0 = ferr_n;
    cs = 1'b0;
    wclk(HALF);
    xfer(8'h04, t);
    xfer(8'h99, t);
    wclk(HALF);
    cs = 1'b1;
    wclk(12);
    chk("t5_ferr", ferr_n - e0, 1);
    chk("t5_noreq", {31'd0, bus.req_valid}, 0);
    frame(8'h04, 8'h99, 8'h00, 8'h3C, r0, r1);
    chk("t5_stat", {24'd0, r0}, 32'h00);
    chk("t5_cmd", {24'd0, bus.req_cmd}, 32'h04);
    chk("t5_addr", {16'd0, bus.req_addr}, 32'h0099);
    chk("t5_wdata", {24'd0, bus.req_wdata}, 32'h3C);
    handshake();
    respond(8'h00);

    // 6: two frames under one CS, then reset mid-byte
    e0 = ferr_n;
    cs = 1'b0;
    wclk(HALF);
    send4(8'h00, 8'h00, 8'h00, 8'h00, r0, r1);
    chk("t6_statA", {24'd0, r0}, 32'h40);
    send4(8'h03, 8'h10, 8'h20, 8'h00, r0, r1);
    chk("t6_statB", {24'd0, r0}, 32'h00);
    wclk(HALF);
    cs = 1'b1;
    wclk(12);
    chk("t6_ferr", ferr_n - e0, 0);
    chk("t6_cmd", {24'd0, bus.req_cmd}, 32'h03);
    chk("t6_addr", {16'd0, bus.req_addr}, 32'h2010);
    chk("t6_valid", {31'd0, bus.req_valid}, 1);
    cs = 1'b0;
    wclk(HALF);
    xfer(8'h02, t);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1;
      wclk(HALF);
      sclk = 1'b1;
      wclk(HALF);
      sclk = 1'b0;
    end
    z80_reset = 1'b0;
    wclk(2);
    chk("t6_r_valid", {31'd0, bus.req_valid}, 0);
    chk("t6_r_cmd", {24'd0, bus.req_cmd}, 0);
    chk("t6_r_miso", {31'd0, miso}, 0);
    chk("t6_r_ferr", {31'd0, frame_err}, 0);
    z80_reset = 1'b1;
    wclk(HALF);
    e0 = ferr_n;
    cs = 1'b1;
    wclk(12);
    chk("t6_r_noerr", ferr_n - e0, 0);
    frame(8'h01, 8'h55, 8'h66, 8'h00, r0, r1);
    chk("t6_n_stat", {24'd0, r0}, 32'h00);
    chk("t6_n_valid", {31'd0, bus.req_valid}, 1);
    chk("t6_n_cmd", {24'd0, bus.req_cmd}, 32'h01);
    chk("t6_n_addr", {16'd0, bus.req_addr}, 32'h6655);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
